// File: rtl/reg8_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, 8 data bits LSB-first, stop bit.
// Define REG8_TX_PARITY_EN to insert an even-parity bit between data and stop.
module reg8_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [DATA_W-1:0] reg_now,
    output logic              ready,
    output logic              busy,
    output logic              tx_out,
    output logic              done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef REG8_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              bit_end;
`ifdef REG8_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef REG8_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef REG8_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
`ifdef REG8_TX_PARITY_EN
        parity_d = parity_q;
`endif
        // Baud counter only runs inside a frame; it wraps to 0 on every bit boundary.
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (LOAD) begin
                    state_d  = StStart;
                    shift_d  = reg_now;
                    bit_d    = '0;
                    baud_d   = '0;
                    tx_d     = 1'b0;
`ifdef REG8_TX_PARITY_EN
                    parity_d = ^reg_now;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef REG8_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef REG8_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    assign tx_out = tx_q;
    assign done   = done_q;
    assign ready  = ready_q;
    assign busy   = ~ready_q;

endmodule

// File: doc/reg8_serial_tx.md
Name: reg8_serial_tx

Overview:
- Parallel-in, serial-out transmitter: the read-out end of the 8-bit parallel-load register path.
- Captures an 8-bit register value on a LOAD handshake and shifts it out LSB-first on a single line as a framed word (start, data, optional parity, stop).
- Sits downstream of the 8-bit register bank, which drives reg_now; a serial link or receiver consumes tx_out.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 1..65535.
- DATA_W, 8, data bits per frame; fixed at 8 for this block.

Ports:
- CLK  input  1  single clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- LOAD  input  1  transmit request, sampled on the rising edge of CLK.
- reg_now  input  8  parallel data, captured when LOAD is accepted.
- ready  output  1  1 = idle, LOAD will be accepted this cycle.
- busy  output  1  1 = frame in progress; always equal to ~ready.
- tx_out  output  1  serial line; idles at 1.
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, tx_out=1, ready=1, busy=0, done=0.
  - Shift register, bit counter and baud counter cleared.
  - Reset takes effect immediately mid-frame; the partial frame is abandoned.
  - After release, the first edge is treated as IDLE.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Accept rule:
  - An edge with state=IDLE and LOAD=1 captures reg_now into an 8-bit shift register and enters START.
  - tx_out is registered and drives 0 starting with that edge.
- Bit timing:
  - Every bit is held for exactly CLKS_PER_BIT cycles, using a baud counter that counts 0..CLKS_PER_BIT-1.
  - A state or bit advances on the edge where the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
- START: tx_out=0 for one bit time.
- DATA:
  - tx_out = shift_reg[0]; the register shifts right one bit per bit time.
  - A 3-bit counter tracks bits 0..7; leave DATA after bit 7.
- PARITY (macro only): see Optional Feature.
- STOP: tx_out=1 for one bit time.
- End of frame:
  - On the edge that ends STOP, go to IDLE with ready=1 and done=1 for exactly one cycle.
  - Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- LOAD while busy: ignored. No queueing, and reg_now changes mid-frame do not affect the frame in flight.
- Back-to-back: LOAD=1 in the done cycle (state=IDLE) is accepted, so the next start bit begins with no idle gap beyond that cycle.
- LOAD held high continuously: frames repeat, each separated by exactly one idle cycle (tx_out=1).
- CLKS_PER_BIT=1: every bit lasts one cycle; the counter compare is always true.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: REG8_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_out = XOR of the 8 captured bits (even parity), held for one bit time.
  - Frame length is 11 bits.
  - The parity value is computed at capture time from reg_now and stored in a flop.
- Undefined:
  - No PARITY state and no parity flop; DATA goes directly to STOP.
  - Frame length is 10 bits.

Test Plan:
- CLKS_PER_BIT=4, no parity; LOAD=1 for one cycle with reg_now=0xA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy=1 for 40 cycles; done pulses 1 cycle on edge 40; ready=1 on the same edge.
- REG8_TX_PARITY_EN defined, CLKS_PER_BIT=4:
  - reg_now=0xA5 -> parity bit 0, frame 44 cycles.
  - reg_now=0x07 -> sequence 0,1,1,1,0,0,0,0,0,1,1, parity bit 1.
- LOAD pulsed again at cycle 12 of a 0xA5 frame with reg_now=0xFF -> ignored; the frame stays 0xA5 unchanged and no second frame follows.
- LOAD held high with alternating data 0x01 then 0x80 -> two frames, separated by exactly one cycle at tx_out=1 in the done cycle; second frame's data bits are 0,0,0,0,0,0,0,1.
- RESET driven low during data bit 3 of a frame -> tx_out=1, ready=1, busy=0, done=0 immediately, without waiting for an edge; after release, LOAD with 0x3C -> a clean full frame.
- CLKS_PER_BIT=1, reg_now=0x55 -> 10-cycle frame 0,1,0,1,0,1,0,1,0,1; done on edge 10.
